// File: rtl/rom_ctrl_sweep_seq.sv
// rom_ctrl_sweep_seq: walks a scrambled ROM word by word and streams each word downstream.
// Build option ROM_CTRL_SWEEP_ADDR_CHECK_EN adds a redundant, cross-checked tweak-address counter.
module rom_ctrl_sweep_seq #(
   parameter  int Width       = 40,
   parameter  int Depth       = 16,
   parameter  int NumTopWords = 8,
   localparam int Aw          = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   output logic             rom_req_o,
   output logic [Aw-1:0]    rom_addr_o,
   output logic [Aw-1:0]    prince_addr_o,
   input  logic             rom_rvalid_i,
   input  logic [Width-1:0] rom_rdata_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_data_o,
   output logic             out_top_o,
   output logic             out_last_o,
   output logic             done_o,
   output logic             err_o
);

   localparam logic [Aw-1:0] TopStart = Aw'(Depth - NumTopWords);
   localparam logic [Aw-1:0] LastIdx  = Aw'(Depth - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_OUT   = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } state_e;

   state_e           state_r;
   state_e           state_next_s;
   logic             addr_clr_s;
   logic             addr_inc_s;
   logic             capture_s;
   logic             fault_s;
   logic             addr_mismatch_s;
   logic             top_hit_s;
   logic             last_hit_s;

   logic             rom_req_r;
   logic             out_valid_r;
   logic             done_r;
   logic             err_r;
   logic [Width-1:0] data_r;
   logic             top_r;
   logic             last_r;
   logic [Aw-1:0]    rom_addr_r;

   assign top_hit_s  = (rom_addr_r >= TopStart);
   assign last_hit_s = (rom_addr_r == LastIdx);

`ifdef ROM_CTRL_SWEEP_ADDR_CHECK_EN
   logic [Aw-1:0]    prince_addr_r;

   assign addr_mismatch_s = (rom_addr_r != prince_addr_r);
   assign prince_addr_o   = prince_addr_r;

   // independent tweak-address counter, kept in lockstep with rom_addr_r
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prince_addr_r <= {Aw{1'b0}};
      end else if ((state_next_s == ST_ERROR) || addr_clr_s) begin
         prince_addr_r <= {Aw{1'b0}};
      end else if (addr_inc_s) begin
         prince_addr_r <= prince_addr_r + Aw'(1);
      end else begin
         prince_addr_r <= prince_addr_r;
      end
   end
`else
   assign addr_mismatch_s = 1'b0;
   assign prince_addr_o   = rom_addr_r;
`endif

   // next-state decode; a fault overrides every other action
   always_comb begin
      state_next_s = state_r;
      addr_clr_s   = 1'b0;
      addr_inc_s   = 1'b0;
      capture_s    = 1'b0;
      fault_s      = 1'b0;

      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_next_s = ST_REQ;
               addr_clr_s   = 1'b1;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_REQ: begin
            state_next_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (rom_rvalid_i) begin
               state_next_s = ST_OUT;
               capture_s    = 1'b1;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_OUT: begin
            if (out_ready_i && last_hit_s) begin
               state_next_s = ST_DONE;
            end else if (out_ready_i) begin
               state_next_s = ST_REQ;
               addr_inc_s   = 1'b1;
            end else begin
               state_next_s = ST_OUT;
            end
         end
         ST_ERROR: begin
            state_next_s = ST_ERROR;
         end
         default: begin
            state_next_s = ST_ERROR;
         end
      endcase

      // a response is legal only while one is outstanding
      if ((state_r != ST_WAIT) && rom_rvalid_i) begin
         fault_s = 1'b1;
      end else if (addr_mismatch_s) begin
         fault_s = 1'b1;
      end else begin
         fault_s = 1'b0;
      end

      if (fault_s) begin
         state_next_s = ST_ERROR;
         addr_clr_s   = 1'b0;
         addr_inc_s   = 1'b0;
         capture_s    = 1'b0;
      end else begin
         state_next_s = state_next_s;
      end
   end

   // state register and control outputs, registered from the next state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= ST_IDLE;
         rom_req_r   <= 1'b0;
         out_valid_r <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         rom_req_r   <= (state_next_s == ST_REQ);
         out_valid_r <= (state_next_s == ST_OUT);
         done_r      <= (state_next_s == ST_DONE);
         err_r       <= (state_next_s == ST_ERROR);
      end
   end

   // read address counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rom_addr_r <= {Aw{1'b0}};
      end else if ((state_next_s == ST_ERROR) || addr_clr_s) begin
         rom_addr_r <= {Aw{1'b0}};
      end else if (addr_inc_s) begin
         rom_addr_r <= rom_addr_r + Aw'(1);
      end else begin
         rom_addr_r <= rom_addr_r;
      end
   end

   // output buffer: loaded on the response, held through back-pressure, wiped on error
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_r <= {Width{1'b0}};
         top_r  <= 1'b0;
         last_r <= 1'b0;
      end else if (state_next_s == ST_ERROR) begin
         data_r <= {Width{1'b0}};
         top_r  <= 1'b0;
         last_r <= 1'b0;
      end else if (capture_s) begin
         data_r <= rom_rdata_i;
         top_r  <= top_hit_s;
         last_r <= last_hit_s;
      end else begin
         data_r <= data_r;
         top_r  <= top_r;
         last_r <= last_r;
      end
   end

   assign rom_req_o   = rom_req_r;
   assign rom_addr_o  = rom_addr_r;
   assign out_valid_o = out_valid_r;
   assign out_data_o  = data_r;
   assign out_top_o   = top_r;
   assign out_last_o  = last_r;
   assign done_o      = done_r;
   assign err_o       = err_r;

endmodule

// File: tb/tb_rom_ctrl_sweep_seq.sv
// Directed bench for rom_ctrl_sweep_seq: ROM model returns addr*3 one cycle after each request.
module tb_rom_ctrl_sweep_seq;
   localparam int Width       = 40;
   localparam int Depth       = 16;
   localparam int NumTopWords = 8;
   localparam int Aw          = 4;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             start_i;
   logic             rom_req_o;
   logic [Aw-1:0]    rom_addr_o;
   logic [Aw-1:0]    prince_addr_o;
   logic             rom_rvalid_i;
   logic [Width-1:0] rom_rdata_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [Width-1:0] out_data_o;
   logic             out_top_o;
   logic             out_last_o;
   logic             done_o;
   logic             err_o;

   logic             model_rvalid;
   logic             inject_rvalid;
   logic             pend;
   logic [Aw-1:0]    pend_addr;
   logic             overlap;
   logic             prince_diff;
   int               req_cnt;
   int               xfer_cnt;
   int               errors = 0;
   int               checks = 0;
   logic [Aw-1:0]    req_addr [0:31];
   logic [Width-1:0] got_data [0:31];
   logic             got_top  [0:31];
   logic             got_last [0:31];

   assign rom_rvalid_i = model_rvalid | inject_rvalid;

   rom_ctrl_sweep_seq #(
      .Width       (Width),
      .Depth       (Depth),
      .NumTopWords (NumTopWords)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .rom_req_o     (rom_req_o),
      .rom_addr_o    (rom_addr_o),
      .prince_addr_o (prince_addr_o),
      .rom_rvalid_i  (rom_rvalid_i),
      .rom_rdata_i   (rom_rdata_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_data_o    (out_data_o),
      .out_top_o     (out_top_o),
      .out_last_o    (out_last_o),
      .done_o        (done_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   // request logger and stream collector (sees pre-edge values)
   always @(posedge clk_i) begin
      if (rst_ni && rom_req_o) begin
         if (pend) overlap = 1'b1;
         if (req_cnt < 32) req_addr[req_cnt] = rom_addr_o;
         req_cnt++;
         pend      = 1'b1;
         pend_addr = rom_addr_o;
      end
      if (rst_ni && out_valid_o && out_ready_i) begin
         if (xfer_cnt < 32) begin
            got_data[xfer_cnt] = out_data_o;
            got_top[xfer_cnt]  = out_top_o;
            got_last[xfer_cnt] = out_last_o;
         end
         xfer_cnt++;
      end
   end

   // ROM response: one cycle after the request; dropped on reset
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         pend         = 1'b0;
         model_rvalid = 1'b0;
      end else if (pend) begin
         model_rvalid = 1'b1;
         rom_rdata_i  = Width'(pend_addr) * Width'(3);
         pend         = 1'b0;
      end else begin
         model_rvalid = 1'b0;
      end
`ifndef ROM_CTRL_SWEEP_ADDR_CHECK_EN
      if (prince_addr_o !== rom_addr_o) prince_diff = 1'b1;
`endif
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      req_cnt  = 0;
      xfer_cnt = 0;
      start_i  = 1'b1;
      @(negedge clk_i);
      start_i  = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (!done_o && n < bound) begin
         @(negedge clk_i);
         n++;
      end
      check_val("done_wait", 64'(done_o), 64'(1));
   endtask

   task automatic wait_valid(input int bound);
      int n = 0;
      while (!out_valid_o && n < bound) begin
         @(negedge clk_i);
         n++;
      end
      check_val("valid_wait", 64'(out_valid_o), 64'(1));
   endtask

   task automatic wait_req(input logic [Aw-1:0] a, input int bound);
      int n = 0;
      while (!(rom_req_o && rom_addr_o == a) && n < bound) begin
         @(negedge clk_i);
         n++;
      end
      check_val("req_wait", 64'({rom_req_o, rom_addr_o}), 64'({1'b1, a}));
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_req"},    64'(rom_req_o),     64'(0));
      check_val({tag, "_addr"},   64'(rom_addr_o),    64'(0));
      check_val({tag, "_prince"}, 64'(prince_addr_o), 64'(0));
      check_val({tag, "_valid"},  64'(out_valid_o),   64'(0));
      check_val({tag, "_data"},   64'(out_data_o),    64'(0));
      check_val({tag, "_top"},    64'(out_top_o),     64'(0));
      check_val({tag, "_last"},   64'(out_last_o),    64'(0));
      check_val({tag, "_done"},   64'(done_o),        64'(0));
   endtask

   task automatic check_sweep(input string tag);
      check_val({tag, "_xfer_cnt"}, 64'(xfer_cnt), 64'(Depth));
      check_val({tag, "_req_cnt"},  64'(req_cnt),  64'(Depth));
      check_val({tag, "_overlap"},  64'(overlap),  64'(0));
      for (int i = 0; i < Depth; i++) begin
         check_val($sformatf("%s_data[%0d]", tag, i), 64'(got_data[i]), 64'(i * 3));
         check_val($sformatf("%s_top[%0d]", tag, i),  64'(got_top[i]),  64'(i >= Depth - NumTopWords));
         check_val($sformatf("%s_last[%0d]", tag, i), 64'(got_last[i]), 64'(i == Depth - 1));
         check_val($sformatf("%s_raddr[%0d]", tag, i), 64'(req_addr[i]), 64'(i));
      end
   endtask

   initial begin
      rst_ni        = 1'b1;
      start_i       = 1'b0;
      out_ready_i   = 1'b1;
      inject_rvalid = 1'b0;
      model_rvalid  = 1'b0;
      rom_rdata_i   = '0;
      pend          = 1'b0;
      pend_addr     = '0;
      overlap       = 1'b0;
      prince_diff   = 1'b0;
      req_cnt       = 0;
      xfer_cnt      = 0;
      #3 rst_ni = 1'b0;
      #2;
      check_outputs_zero("rst");
      check_val("rst_err", 64'(err_o), 64'(0));
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      check_val("idle_req", 64'(rom_req_o), 64'(0));
      check_val("idle_req_cnt", 64'(req_cnt), 64'(0));

      // full sweep, ready tied high
      pulse_start();
      wait_done(200);
      check_sweep("sweep1");
      check_val("sweep1_err", 64'(err_o), 64'(0));

      // restart from DONE with ready low: done drops next cycle, request at 0
      out_ready_i = 1'b0;
      pulse_start();
      check_val("restart_done", 64'(done_o), 64'(0));
      check_val("restart_req", 64'(rom_req_o), 64'(1));
      check_val("restart_addr", 64'(rom_addr_o), 64'(0));
      wait_valid(20);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_val("ign_start_valid", 64'(out_valid_o), 64'(1));
      check_val("ign_start_data", 64'(out_data_o), 64'(0));
      check_val("ign_start_reqs", 64'(req_cnt), 64'(1));
      check_val("ign_start_addr", 64'(rom_addr_o), 64'(0));

      // back-pressure on word 4
      out_ready_i = 1'b1;
      wait_req(4'd4, 50);
      out_ready_i = 1'b0;
      wait_valid(20);
      for (int k = 0; k < 5; k++) begin
         check_val("bp_valid", 64'(out_valid_o), 64'(1));
         check_val("bp_data", 64'(out_data_o), 64'(12));
         check_val("bp_req", 64'(rom_req_o), 64'(0));
         @(negedge clk_i);
      end
      check_val("bp_xfer_cnt", 64'(xfer_cnt), 64'(4));
      out_ready_i = 1'b1;
      wait_done(200);
      check_sweep("sweep2");

      // reset while waiting on the response for address 6
      pulse_start();
      wait_req(4'd6, 100);
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check_outputs_zero("midrst");
      check_val("midrst_err", 64'(err_o), 64'(0));
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      check_val("post_rst_err", 64'(err_o), 64'(0));
      check_val("post_rst_req", 64'(rom_req_o), 64'(0));
      pulse_start();
      wait_done(200);
      check_sweep("sweep3");

`ifdef ROM_CTRL_SWEEP_ADDR_CHECK_EN
      // corrupt the redundant counter at address 3
      pulse_start();
      wait_req(4'd3, 100);
      force dut.prince_addr_r = 4'd9;
      @(negedge clk_i);
      check_val("addr_chk_err", 64'(err_o), 64'(1));
      release dut.prince_addr_r;
`else
      check_val("prince_eq_rom", 64'(prince_diff), 64'(0));
`endif

      // spurious response in IDLE -> terminal error
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      check_val("pre_inj_err", 64'(err_o), 64'(0));
      inject_rvalid = 1'b1;
      @(negedge clk_i);
      inject_rvalid = 1'b0;
      check_val("inj_err", 64'(err_o), 64'(1));
      check_outputs_zero("inj");
      pulse_start();
      repeat (5) @(negedge clk_i);
      check_val("err_sticky", 64'(err_o), 64'(1));
      check_val("err_no_req", 64'(req_cnt), 64'(0));
      check_outputs_zero("err_hold");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
